// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the instruction/data memory arbiter
package rv32i_types;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  // IDLE samples both ports, ACCESS_* own the backend, RESPOND releases both ports together
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS_B = 2'd1,
    ACCESS_A = 2'd2,
    RESPOND  = 2'd3
  } arb_state_t;

  // One port's request as frozen at sampling time; write wins over read
  typedef struct packed {
    logic              valid;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   byte_enable;
  } port_req_t;

  function automatic logic is_request(input logic read, input logic write);
    return read | write;
  endfunction

  function automatic port_req_t make_req(
    input logic              read,
    input logic              write,
    input logic [ADDR_W-1:0] address,
    input logic [DATA_W-1:0] wdata,
    input logic [BE_W-1:0]   byte_enable
  );
    port_req_t r;
    r.valid       = is_request(read, write);
    r.write       = write;
    r.address     = address;
    r.wdata       = wdata;
    r.byte_enable = byte_enable;
    return r;
  endfunction

endpackage

// File: rtl/arb_req_latch.sv
// rtl/arb_req_latch.sv - per-port request capture register for the arbiter
module arb_req_latch
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   byte_enable,
  output port_req_t         req
);

  // Reload every sampling cycle, otherwise freeze so CPU-side changes are ignored mid-transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      req <= '0;
    end else if (capture) begin
      req <= make_req(read, write, address, wdata, byte_enable);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction A / data B) arbiter onto one backend memory
module mem_arbiter
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              reset,

  input  logic              cmem_read_a,
  input  logic              cmem_write_a,
  input  logic [ADDR_W-1:0] cmem_address_a,
  input  logic [DATA_W-1:0] cmem_wdata_a,
  input  logic [BE_W-1:0]   cmem_byte_enable_a,
  output logic              cmem_resp_a,
  output logic [DATA_W-1:0] cmem_rdata_a,

  input  logic              cmem_read_b,
  input  logic              cmem_write_b,
  input  logic [ADDR_W-1:0] cmem_address_b,
  input  logic [DATA_W-1:0] cmem_wdata_b,
  input  logic [BE_W-1:0]   cmem_byte_enable_b,
  output logic              cmem_resp_b,
  output logic [DATA_W-1:0] cmem_rdata_b,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [BE_W-1:0]   pmem_byte_enable,
  input  logic              pmem_resp,
  input  logic [DATA_W-1:0] pmem_rdata
);

  arb_state_t  state;
  port_req_t   req_a;
  port_req_t   req_b;
  port_req_t   sel;
  logic        capture;
  logic        resp_a_q;
  logic        resp_b_q;
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  assign capture = (state == IDLE);

  arb_req_latch u_latch_a (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture),
    .read        (cmem_read_a),
    .write       (cmem_write_a),
    .address     (cmem_address_a),
    .wdata       (cmem_wdata_a),
    .byte_enable (cmem_byte_enable_a),
    .req         (req_a)
  );

  arb_req_latch u_latch_b (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture),
    .read        (cmem_read_b),
    .write       (cmem_write_b),
    .address     (cmem_address_b),
    .wdata       (cmem_wdata_b),
    .byte_enable (cmem_byte_enable_b),
    .req         (req_b)
  );

  // Sequencer: B before A, both responses raised together on entry to RESPOND
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      resp_a_q  <= 1'b0;
      resp_b_q  <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_a_q <= 1'b0;
          resp_b_q <= 1'b0;
          if (is_request(cmem_read_b, cmem_write_b)) begin
            state <= ACCESS_B;
          end else if (is_request(cmem_read_a, cmem_write_a)) begin
            state <= ACCESS_A;
          end
        end
        ACCESS_B: begin
          if (pmem_resp) begin
            rdata_b_q <= pmem_rdata;
            if (req_a.valid) begin
              state <= ACCESS_A;
            end else begin
              state    <= RESPOND;
              resp_b_q <= 1'b1;
            end
          end
        end
        ACCESS_A: begin
          if (pmem_resp) begin
            rdata_a_q <= pmem_rdata;
            state     <= RESPOND;
            resp_a_q  <= 1'b1;
            resp_b_q  <= req_b.valid;
          end
        end
        RESPOND: begin
          resp_a_q <= 1'b0;
          resp_b_q <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Backend request comes only from the frozen latch of the port being served
  always_comb begin
    sel = '0;
    case (state)
      ACCESS_B: sel = req_b;
      ACCESS_A: sel = req_a;
      default:  sel = '0;
    endcase
  end

  assign pmem_read        = sel.valid & ~sel.write;
  assign pmem_write       = sel.valid & sel.write;
  assign pmem_address     = sel.address;
  assign pmem_wdata       = sel.wdata;
  assign pmem_byte_enable = sel.byte_enable;

  assign cmem_resp_a  = resp_a_q;
  assign cmem_resp_b  = resp_b_q;
  assign cmem_rdata_a = rdata_a_q;
  assign cmem_rdata_b = rdata_b_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a backend model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmem_read_a, cmem_write_a, cmem_read_b, cmem_write_b;
  logic [31:0] cmem_address_a, cmem_wdata_a, cmem_address_b, cmem_wdata_b;
  logic [3:0]  cmem_byte_enable_a, cmem_byte_enable_b;
  logic        cmem_resp_a, cmem_resp_b;
  logic [31:0] cmem_rdata_a, cmem_rdata_b;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [3:0]  pmem_byte_enable;

  int total = 0;
  int bad = 0;

  // backend model controls and access log
  int          be_lat = 3;
  logic        be_auto = 1'b1;
  logic        force_resp = 1'b0;
  logic [31:0] force_data = 32'h0;
  int          acc_cnt = 0;
  logic        snap_stable;
  logic [31:0] snap_addr, snap_wd;
  logic [3:0]  snap_be;
  logic        snap_rd, snap_wr;
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] log_addr [$];
  logic        log_wr [$];
  logic [31:0] log_wd [$];
  logic [3:0]  log_be [$];
  logic        log_stable [$];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cmem_read_a(cmem_read_a), .cmem_write_a(cmem_write_a),
    .cmem_address_a(cmem_address_a), .cmem_wdata_a(cmem_wdata_a),
    .cmem_byte_enable_a(cmem_byte_enable_a),
    .cmem_resp_a(cmem_resp_a), .cmem_rdata_a(cmem_rdata_a),
    .cmem_read_b(cmem_read_b), .cmem_write_b(cmem_write_b),
    .cmem_address_b(cmem_address_b), .cmem_wdata_b(cmem_wdata_b),
    .cmem_byte_enable_b(cmem_byte_enable_b),
    .cmem_resp_b(cmem_resp_b), .cmem_rdata_b(cmem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // backend: responds in the max(be_lat,1)-th cycle of an access, logs each completed access
  initial begin
    logic [31:0] cur;
    pmem_resp = 1'b0;
    pmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (be_auto && !reset && (pmem_read || pmem_write)) begin
        if (acc_cnt == 0) begin
          snap_addr = pmem_address; snap_wd = pmem_wdata; snap_be = pmem_byte_enable;
          snap_rd = pmem_read; snap_wr = pmem_write; snap_stable = 1'b1;
        end else if (snap_addr !== pmem_address || snap_wd !== pmem_wdata || snap_be !== pmem_byte_enable ||
                     snap_rd !== pmem_read || snap_wr !== pmem_write) begin
          snap_stable = 1'b0;
        end
        acc_cnt++;
        if (acc_cnt >= ((be_lat == 0) ? 1 : be_lat)) begin
          cur = bmem.exists(pmem_address) ? bmem[pmem_address] : init_word(pmem_address);
          pmem_rdata = cur;
          if (pmem_write) bmem[pmem_address] = merge(cur, pmem_wdata, pmem_byte_enable);
          pmem_resp = 1'b1;
          log_addr.push_back(pmem_address);
          log_wr.push_back(pmem_write);
          log_wd.push_back(pmem_wdata);
          log_be.push_back(pmem_byte_enable);
          log_stable.push_back(snap_stable);
          acc_cnt = 0;
        end else begin
          pmem_resp = 1'b0;
        end
      end else begin
        acc_cnt = 0;
        pmem_resp = be_auto ? 1'b0 : force_resp;
        pmem_rdata = be_auto ? 32'h0 : force_data;
      end
    end
  end

  task automatic set_a(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    cmem_read_a = rd; cmem_write_a = wr; cmem_address_a = a; cmem_wdata_a = wd; cmem_byte_enable_a = be;
  endtask

  task automatic set_b(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    cmem_read_b = rd; cmem_write_b = wr; cmem_address_b = a; cmem_wdata_b = wd; cmem_byte_enable_b = be;
  endtask

  task automatic clear_log();
    log_addr.delete(); log_wr.delete(); log_wd.delete(); log_be.delete(); log_stable.delete();
  endtask

  // cycle count includes the sampling cycle in which the request was driven
  task automatic wait_resp(input string tag, output int cyc, output logic ga, output logic gb);
    cyc = 1; ga = 1'b0; gb = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (cmem_resp_a || cmem_resp_b) begin
        ga = cmem_resp_a; gb = cmem_resp_b;
        break;
      end
    end
    if (!(ga || gb)) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // the cycle after RESPOND must show both responses low again
  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check_eq({tag, "_pulse_end"}, 32'({cmem_resp_a, cmem_resp_b}), 32'd0);
  endtask

  initial begin
    int cyc;
    logic ga, gb, quiet;
    logic [31:0] aa, ba, bwd, exp_a, exp_b;
    logic [3:0] bbe;
    logic bwr;

    reset = 1'b1;
    set_a(0, 0, 32'h0, 32'h0, 4'h0);
    set_b(0, 0, 32'h0, 32'h0, 4'h0);
    bmem[32'h60] = 32'h00A0_0093;
    bmem[32'h64] = 32'h1234_5678;
    bmem[32'h200] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check_eq("rst_resp", 32'({cmem_resp_a, cmem_resp_b}), 32'd0);
    check_eq("rst_pmem_rw", 32'({pmem_read, pmem_write}), 32'd0);
    check_eq("rst_pmem_addr", pmem_address, 32'h0);
    check_eq("rst_pmem_wdata", pmem_wdata, 32'h0);
    check_eq("rst_pmem_be", 32'(pmem_byte_enable), 32'h0);
    check_eq("rst_rdata_a", cmem_rdata_a, 32'h0);
    check_eq("rst_rdata_b", cmem_rdata_b, 32'h0);

    // A-only read
    clear_log();
    set_a(1, 0, 32'h60, 32'h0, 4'hF);
    wait_resp("t1", cyc, ga, gb);
    set_a(0, 0, 32'h0, 32'h0, 4'h0);
    check_eq("t1_resp", 32'({ga, gb}), 32'b10);
    check_eq("t1_rdata_a", cmem_rdata_a, 32'h00A0_0093);
    check_eq("t1_cycles", 32'(cyc), 32'd5);
    check_eq("t1_accesses", 32'(log_addr.size()), 32'd1);
    check_eq("t1_addr", log_addr[0], 32'h60);
    check_pulse_end("t1");

    // joint read, B served first
    clear_log();
    set_a(1, 0, 32'h64, 32'h0, 4'hF);
    set_b(1, 0, 32'h200, 32'h0, 4'hF);
    wait_resp("t2", cyc, ga, gb);
    set_a(0, 0, 32'h0, 32'h0, 4'h0);
    set_b(0, 0, 32'h0, 32'h0, 4'h0);
    check_eq("t2_joint", 32'({ga, gb}), 32'b11);
    check_eq("t2_order0", log_addr[0], 32'h200);
    check_eq("t2_order1", log_addr[1], 32'h64);
    check_eq("t2_rdata_b", cmem_rdata_b, 32'hDEAD_BEEF);
    check_eq("t2_rdata_a", cmem_rdata_a, 32'h1234_5678);
    check_eq("t2_cycles", 32'(cyc), 32'd8);
    check_pulse_end("t2");

    // B partial write with A read
    clear_log();
    set_a(1, 0, 32'h64, 32'h0, 4'hF);
    set_b(0, 1, 32'h300, 32'hCAFE_F00D, 4'b0011);
    wait_resp("t3", cyc, ga, gb);
    set_a(0, 0, 32'h0, 32'h0, 4'h0);
    set_b(0, 0, 32'h0, 32'h0, 4'h0);
    check_eq("t3_joint", 32'({ga, gb}), 32'b11);
    check_eq("t3_wr_addr", log_addr[0], 32'h300);
    check_eq("t3_wr_flag", 32'(log_wr[0]), 32'd1);
    check_eq("t3_wr_data", log_wd[0], 32'hCAFE_F00D);
    check_eq("t3_wr_be", 32'(log_be[0]), 32'b0011);
    check_eq("t3_wr_stable", 32'(log_stable[0]), 32'd1);
    check_eq("t3_rd_addr", log_addr[1], 32'h64);
    check_eq("t3_rd_flag", 32'(log_wr[1]), 32'd0);
    check_eq("t3_rdata_a", cmem_rdata_a, 32'h1234_5678);
    check_pulse_end("t3");

    // B arrives one cycle after A was sampled
    clear_log();
    set_a(1, 0, 32'h60, 32'h0, 4'hF);
    @(negedge clk);
    set_b(1, 0, 32'h200, 32'h0, 4'hF);
    check_eq("t4_serving_a", pmem_address, 32'h60);
    wait_resp("t4a", cyc, ga, gb);
    check_eq("t4_a_alone", 32'({ga, gb}), 32'b10);
    check_eq("t4_a_accesses", 32'(log_addr.size()), 32'd1);
    check_pulse_end("t4a");
    clear_log();
    wait_resp("t4b", cyc, ga, gb);
    set_a(0, 0, 32'h0, 32'h0, 4'h0);
    set_b(0, 0, 32'h0, 32'h0, 4'h0);
    check_eq("t4_joint", 32'({ga, gb}), 32'b11);
    check_eq("t4_order0", log_addr[0], 32'h200);
    check_eq("t4_order1", log_addr[1], 32'h60);
    check_eq("t4_rdata_b", cmem_rdata_b, 32'hDEAD_BEEF);
    check_pulse_end("t4b");

    // reset during ACCESS_B, stray backend response afterwards
    set_b(1, 0, 32'h200, 32'h0, 4'hF);
    @(negedge clk);
    check_eq("t5_in_access", 32'(pmem_read), 32'd1);
    be_auto = 1'b0;
    force_resp = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_b(0, 0, 32'h0, 32'h0, 4'h0);
    force_data = 32'hBAD0_BAD0;
    force_resp = 1'b1;
    check_eq("t5_reset_pmem", 32'({pmem_read, pmem_write}), 32'd0);
    check_eq("t5_reset_resp", 32'({cmem_resp_a, cmem_resp_b}), 32'd0);
    @(negedge clk);
    force_resp = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (cmem_resp_a || cmem_resp_b || pmem_read || pmem_write) quiet = 1'b0;
      @(negedge clk);
    end
    check_eq("t5_quiet", 32'(quiet), 32'd1);
    check_eq("t5_rdata_b", cmem_rdata_b, 32'h0);
    be_auto = 1'b1;

    // randomized latency, dual requests against a reference memory
    for (int n = 0; n < 100; n++) begin
      be_lat = $urandom_range(0, 7);
      aa = 32'h400 + 32'($urandom_range(0, 7)) * 4;
      ba = 32'h400 + 32'($urandom_range(0, 7)) * 4;
      bwr = 1'($urandom_range(0, 1));
      bwd = $urandom;
      bbe = 4'($urandom_range(0, 15));
      exp_b = ref_read(ba);
      if (bwr) ref_mem[ba] = merge(exp_b, bwd, bbe);
      exp_a = ref_read(aa);
      set_a(1, 0, aa, 32'h0, 4'hF);
      set_b(!bwr, bwr, ba, bwd, bbe);
      wait_resp("rnd", cyc, ga, gb);
      set_a(0, 0, 32'h0, 32'h0, 4'h0);
      set_b(0, 0, 32'h0, 32'h0, 4'h0);
      check_eq("rnd_joint", 32'({ga, gb}), 32'b11);
      check_eq("rnd_rdata_a", cmem_rdata_a, exp_a);
      if (!bwr) check_eq("rnd_rdata_b", cmem_rdata_b, exp_b);
      check_pulse_end("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
